// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types for the divider-sharing arbiter.
// Operand width, FSM state encoding and the response bundle.
package div_arb_pkg;

  localparam int DIV_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0] quot;
    logic [DIV_W-1:0] rem;
    logic             err;
  } div_rsp_t;

endpackage

// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: requester and response handshakes.
// master = client side, slave = arbiter side.
interface div_share_arbiter_if #(
  parameter int NREQ = 4
) ();
  import div_arb_pkg::*;

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIV_W-1:0] req_dividend;
  logic [NREQ*DIV_W-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [DIV_W-1:0]      rsp_quot;
  logic [DIV_W-1:0]      rsp_rem;
  logic                  rsp_err;

  modport master (
    output req_valid,
    output req_dividend,
    output req_divisor,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_quot,
    input  rsp_rem,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_dividend,
    input  req_divisor,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_quot,
    output rsp_rem,
    output rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick from req and ptr,
// pointer advances past the winner when the grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    take,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] N = (IW+1)'(NREQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt;
  logic [IW:0]   sum;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= N) sum = sum - N;
      if (!any && req[sum[IW-1:0]]) begin
        any = 1'b1;
        idx = sum[IW-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

  assign nxt = (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take && any) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin share of one 7-bit divider.
// DIV_ZERO_BYPASS_EN: answer divide-by-zero without the divider.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  div_share_arbiter_if.slave    bus,
  output logic                  div_start,
  output logic [DIV_W-1:0]      div_dividend,
  output logic [DIV_W-1:0]      div_divisor,
  input  logic [DIV_W-1:0]      div_quot,
  input  logic [DIV_W-1:0]      div_rem,
  input  logic                  div_done,
  output logic                  arb_busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t           state;
  logic [CW-1:0]    cnt;
  div_rsp_t         rsp;
  logic [IW-1:0]    id;
  logic             rsp_valid;
  logic [NREQ-1:0]  ready;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gidx;
  logic             any;
  logic             take;
  logic [DIV_W-1:0] g_dvd;
  logic [DIV_W-1:0] g_dvs;

  assign take = (state == IDLE);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .take  (take),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    g_dvd = '0;
    g_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_dvd = bus.req_dividend[DIV_W*i +: DIV_W];
        g_dvs = bus.req_divisor[DIV_W*i +: DIV_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rsp          <= '0;
      id           <= '0;
      rsp_valid    <= 1'b0;
      ready        <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      ready     <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            ready        <= grant;
            id           <= gidx;
            div_dividend <= g_dvd;
            div_divisor  <= g_dvs;
`ifdef DIV_ZERO_BYPASS_EN
            if (g_dvs == '0) begin
              rsp       <= '{quot: '1, rem: g_dvd, err: 1'b1};
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
`else
            div_start <= 1'b1;
            state     <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            rsp       <= '{quot: div_quot, rem: div_rem, err: 1'b0};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            rsp       <= '{quot: '0, rem: '0, err: 1'b1};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = id;
  assign bus.rsp_quot  = rsp.quot;
  assign bus.rsp_rem   = rsp.rem;
  assign bus.rsp_err   = rsp.err;
  assign arb_busy      = (state != IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scoreboard bench with a behavioural divider,
// round-robin reference and randomized requesters.
module tb_div_share_arbiter;
  import div_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;

  typedef struct {
    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] b;
  } op_t;

  typedef struct {
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] r;
    logic             e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_share_arbiter_if #(.NREQ(NREQ)) bus ();

  logic             div_start;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quot;
  logic [DIV_W-1:0] div_rem;
  logic             div_done;
  logic             arb_busy;

  div_share_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .div_done     (div_done),
    .arb_busy     (arb_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t  req_q[NREQ][$];
  exp_t exp_q[NREQ][$];
  op_t  cur[NREQ];
  int   acc[NREQ];
  int   glog[$];

  int ready_cnt, start_cnt, vld_cnt, hs_cyc, g_cyc;
  int rsp_mode, mptr, gw, gj, rid;
  int pend, lat, st_cyc, st_lat;
  bit hang, rnd, chk_lat, prev_rv, hold;
  logic [NREQ-1:0] prev_valid;
  logic [31:0] held_word;
  logic [DIV_W-1:0] da, db;
  exp_t ex;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t x;
`ifdef DIV_ZERO_BYPASS_EN
    if (o.b == 0) return '{7'h7F, o.a, 1'b1};
`endif
    if (hang) x = '{7'd0, 7'd0, 1'b1};
    else if (o.b == 0) x = '{7'h7F, o.a, 1'b0};
    else x = '{o.a / o.b, o.a % o.b, 1'b0};
    return x;
  endfunction

  function automatic logic [31:0] rsp_word();
    return 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_quot,
                bus.rsp_rem, bus.rsp_err});
  endfunction

  function automatic bit quiet();
    bit q;
    q = (bus.req_valid == '0) && !arb_busy;
    for (int i = 0; i < NREQ; i++)
      q = q && (req_q[i].size() == 0) && (exp_q[i].size() == 0);
    return q;
  endfunction

  // Everything that touches the DUT pins happens on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      bus.req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        acc[i] = 0;
        exp_q[i].delete();
      end
      pend = 0; chk_lat = 0; hold = 0; mptr = 0;
      div_done = 1'b0; prev_valid = '0; prev_rv = 0;
      continue;
    end

    div_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        div_done = 1'b1;
        div_quot = (db == 0) ? 7'h7F : da / db;
        div_rem  = (db == 0) ? da : da % db;
      end
    end else if (rnd && (!arb_busy || bus.rsp_valid) &&
                 $urandom_range(0, 7) == 0) begin
      div_done = 1'b1;
      div_quot = 7'($urandom);
      div_rem  = 7'($urandom);
    end
    if (div_start) begin
      start_cnt++;
      if (rnd) lat = $urandom_range(1, 6);
      da = div_dividend;
      db = div_divisor;
      st_cyc = cyc;
      st_lat = hang ? TIMEOUT + 1 : lat + 1;
      chk_lat = 1;
      if (!hang) pend = lat;
    end

    if (bus.rsp_valid && !prev_rv) begin
      vld_cnt++;
      if (chk_lat) begin
        chk("latency", cyc - st_cyc, st_lat);
        chk_lat = 0;
      end
    end
    prev_rv = bus.rsp_valid;

    if (|bus.req_ready) begin
      ready_cnt++;
      g_cyc = cyc;
      gw = -1;
      for (int k = 0; k < NREQ; k++) begin
        gj = (mptr + k) % NREQ;
        if (gw < 0 && prev_valid[gj]) gw = gj;
      end
      if (gw < 0) begin
        chk("grant_no_req", int'(bus.req_ready), 0);
      end else begin
        chk("grant_onehot", int'(bus.req_ready), 1 << gw);
        mptr = (gw + 1) % NREQ;
        glog.push_back(gw);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i] && acc[i] == 0) begin
          acc[i] = 2;
          exp_q[i].push_back(model(cur[i]));
        end
      end
    end

    case (rsp_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
      default: bus.rsp_ready = 1'b0;
    endcase

    if (hold) chk("rsp_stable", int'(rsp_word()), int'(held_word));
    hold = 0;
    if (bus.rsp_valid) begin
      if (bus.rsp_ready) begin
        hs_cyc = cyc;
        rid = int'(bus.rsp_id);
        if (exp_q[rid].size() == 0) begin
          chk("rsp_unexpected_id", rid, -1);
        end else begin
          ex = exp_q[rid].pop_front();
          chk("rsp_quot", int'(bus.rsp_quot), int'(ex.q));
          chk("rsp_rem", int'(bus.rsp_rem), int'(ex.r));
          chk("rsp_err", int'(bus.rsp_err), int'(ex.e));
        end
      end else begin
        hold = 1;
        held_word = rsp_word();
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] == 2) begin
        acc[i] = 1;
      end else if (acc[i] == 1) begin
        acc[i] = 0;
        bus.req_valid[i] = 1'b0;
      end else if (bus.req_valid[i]) begin
        if (rnd && $urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
      end else if (req_q[i].size() > 0 &&
                   (!rnd || $urandom_range(0, 3) == 0)) begin
        cur[i] = req_q[i].pop_front();
        bus.req_dividend[DIV_W*i +: DIV_W] = cur[i].a;
        bus.req_divisor[DIV_W*i +: DIV_W]  = cur[i].b;
        bus.req_valid[i] = 1'b1;
      end
    end
    prev_valid = bus.req_valid;
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp", int'(rsp_word()), 0);
    chk("rst_div", int'({div_start, div_dividend, div_divisor, arb_busy}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int k = 0; k < bound && !quiet(); k++) @(posedge clk);
    chk(nm, int'(quiet()), 1);
  endtask

  int ord[5] = '{0, 1, 2, 3, 0};
  op_t o;

  initial begin
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b1;
    div_done = 1'b0; div_quot = '0; div_rem = '0;
    hang = 0; rnd = 0; rsp_mode = 0; lat = 3;
    ready_cnt = 0; start_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < NREQ; i++) acc[i] = 0;
    do_reset();

    // single request
    ready_cnt = 0; start_cnt = 0;
    req_q[0].push_back('{7'd100, 7'd7});
    drain("t1_drain", 200);
    chk("t1_ready_pulses", ready_cnt, 1);
    chk("t1_start_pulses", start_cnt, 1);

    // all four contend from pointer 0
    do_reset();
    glog.delete();
    req_q[0].push_back('{7'd100, 7'd7});
    req_q[0].push_back('{7'd99, 7'd98});
    req_q[1].push_back('{7'd50, 7'd3});
    req_q[2].push_back('{7'd127, 7'd10});
    req_q[3].push_back('{7'd8, 7'd9});
    drain("t2_drain", 400);
    chk("t2_grants", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      chk("t2_order", glog[k], ord[k]);

    // response backpressure
    rsp_mode = 2;
    req_q[0].push_back('{7'd77, 7'd5});
    for (int k = 0; k < 100 && !bus.rsp_valid; k++) @(posedge clk);
    chk("t3_rsp_seen", int'(bus.rsp_valid), 1);
    req_q[1].push_back('{7'd66, 7'd4});
    repeat (2) @(posedge clk);
    ready_cnt = 0;
    repeat (10) @(posedge clk);
    chk("t3_no_grant_held", ready_cnt, 0);
    #1 rsp_mode = 0;
    for (int k = 0; k < 50 && ready_cnt == 0; k++) @(posedge clk);
    chk("t3_next_grant_gap", g_cyc - hs_cyc, 2);
    drain("t3_drain", 200);

    // divider never answers
    hang = 1;
    req_q[2].push_back('{7'd20, 7'd3});
    drain("t4_drain", 300);
    hang = 0;

    // divide by zero
    start_cnt = 0;
    req_q[1].push_back('{7'd45, 7'd0});
    drain("t5_drain", 200);
`ifdef DIV_ZERO_BYPASS_EN
    chk("t5_start_pulses", start_cnt, 0);
`else
    chk("t5_start_pulses", start_cnt, 1);
`endif

    // reset in WAIT
    hang = 1; start_cnt = 0;
    req_q[2].push_back('{7'd10, 7'd3});
    for (int k = 0; k < 50 && start_cnt == 0; k++) @(posedge clk);
    chk("t6_started", start_cnt, 1);
    repeat (5) @(posedge clk);
    do_reset();
    hang = 0;
    vld_cnt = 0;
    repeat (20) @(posedge clk);
    chk("t6_no_rsp", vld_cnt, 0);
    glog.delete();
    req_q[3].push_back('{7'd90, 7'd9});
    req_q[1].push_back('{7'd91, 7'd13});
    drain("t6_drain", 300);
    chk("t6_first_grant", (glog.size() > 0) ? glog[0] : -1, 1);

    // randomized traffic
    rnd = 1; rsp_mode = 1;
    for (int n = 0; n < 300; n++) begin
      o.a = 7'($urandom);
      o.b = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      req_q[$urandom_range(0, NREQ-1)].push_back(o);
    end
    drain("rnd_drain", 30000);
    rnd = 0; rsp_mode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
